// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial W-bit subtractor, diff = a - b - bin.
// A single full-subtractor cell works on one bit per clock, LSB first.
// Operands and results move through valid/ready handshakes.
// FSM: IDLE (accept) -> RUN (W edges) -> DONE (hold result until taken).
// Optional macro SERIAL_SUBTRACTOR_OVF_EN builds signed-overflow capture;
// without it ovf is tied low.

module serial_subtractor #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] diff,
   output logic         bout,
   output logic         ovf
);

   // Counter must be able to hold W itself so that W=1 still has a legal width.
   localparam int CNT_W = $clog2(W + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q;
   logic [W-1:0]     a_sh_q;
   logic [W-1:0]     b_sh_q;
   logic [W-1:0]     res_q;
   logic [W-1:0]     diff_q;
   logic             borrow_q;
   logic             bout_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [CNT_W-1:0] cnt_q;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             ovf_q;
`endif

   logic             bitDiff;
   logic             borrow_d;
   logic [W-1:0]     res_d;
   logic [W:0]       resCat;
   logic             lastEdge;

   // Full-subtractor cell on the current LSBs, plus the result shift that
   // pushes the new bit in from the MSB side (the W+1 concat keeps W=1 legal).
   always_comb begin
      bitDiff  = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
      borrow_d = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
      resCat   = {bitDiff, res_q};
      res_d    = resCat[W:1];
      lastEdge = (cnt_q == CNT_W'(W - 1));
   end

   // Control FSM and serial datapath; result outputs are loaded only on the
   // edge that enters DONE so they stay glitch-free while out_valid is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         res_q       <= '0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         bout_q      <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_sh_q     <= a;
                  b_sh_q     <= b;
                  borrow_q   <= bin;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               a_sh_q   <= a_sh_q >> 1;
               b_sh_q   <= b_sh_q >> 1;
               res_q    <= res_d;
               borrow_q <= borrow_d;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (lastEdge) begin
                  diff_q      <= res_d;
                  bout_q      <= borrow_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                  // borrow_q here is the borrow flowing into the MSB cell.
                  ovf_q       <= borrow_d ^ borrow_q;
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign bout      = bout_q;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule
